pool_wb_exec: RTL and testbench
===============================

Name: pool_wb_exec

Overview:
- Write-back executor for the pooling unit: pops one write-back descriptor (addr, mask, last) and one pooled result word per step, then issues the RTM write.
- Sits between the write-back descriptor FIFO, the pooled-data FIFO and the RTM write port.
- Sequences one instruction's write-back from start_pulse to done_pulse, with backpressure from the RTM port.

Parameters:
- ADDR_W, 12, RTM address width (= $clog2(`RTM_DEPTH)).
- DATA_W, 64, pooled result word / RTM write data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_pulse  in  1  one-cycle start of an instruction's write-back.
- desc_empty  in  1  descriptor FIFO empty (FWFT).
- desc_addr  in  ADDR_W  descriptor RTM address.
- desc_mask  in  1  1 = discard this word, no RTM write.
- desc_last  in  1  final descriptor of the instruction.
- desc_rd_en  out  1  descriptor FIFO pop.
- data_empty  in  1  pooled-data FIFO empty (FWFT).
- data_dout  in  DATA_W  pooled result word.
- data_rd_en  out  1  pooled-data FIFO pop.
- rtm_wr_en  out  1  RTM write request valid.
- rtm_wr_addr  out  ADDR_W  RTM write address.
- rtm_wr_data  out  DATA_W  RTM write data.
- rtm_wr_rdy  in  1  RTM accepts the write this cycle.
- busy  out  1  instruction in progress.
- done_pulse  out  1  one cycle when the last write has been accepted.
- n_written  out  16  unmasked writes issued since the last start.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. All outputs 0. Output register empty.
- States:
  - IDLE -> RUN on start_pulse; n_written cleared to 0 in the same cycle.
  - RUN -> DRAIN when a popped descriptor has desc_last=1.
  - DRAIN -> DONE when the output register is empty, or is being accepted this cycle.
  - DONE -> IDLE after one cycle. done_pulse=1 only in DONE.
- busy=1 in RUN, DRAIN and DONE. start_pulse outside IDLE is ignored.
- Output register: rtm_wr_en/addr/data are registered. Register is free when rtm_wr_en=0, or when rtm_wr_en=1 and rtm_wr_rdy=1.
- Pop condition (combinational): state==RUN, ~desc_empty, ~data_empty and register free. When true:
  - desc_rd_en=1 and data_rd_en=1 in the same cycle. The two FIFOs always pop in lockstep.
- On a pop with desc_mask=0:
  - next cycle rtm_wr_en=1, rtm_wr_addr=desc_addr, rtm_wr_data=data_dout.
  - n_written increments by 1, saturating at 16'hFFFF.
- On a pop with desc_mask=1: the data word is consumed and discarded. The register loads rtm_wr_en=0, or keeps draining.
- Hold rule: while rtm_wr_en=1 and rtm_wr_rdy=0, addr/data are held stable and no pop occurs.
- Latency and throughput:
  - Pop to rtm_wr_en: 1 cycle.
  - Sustained rate: 1 write/cycle with rtm_wr_rdy=1 and both FIFOs non-empty.
- Last descriptor:
  - No further pops after the pop carrying desc_last, even if the FIFOs are non-empty (those words belong to the next instruction).
  - A masked last descriptor still ends the instruction; DRAIN then completes as soon as the register is empty.
- Async reset mid-operation: immediate return to IDLE. The in-flight RTM write is dropped and the FIFOs are not touched.
- FWFT FIFOs: rd_en is never asserted while the corresponding empty=1.

Test Plan:
- Basic run: start, 4 descriptors addr 0x10..0x13 (mask=0, last on 4th), data 0xA0..0xA3, rtm_wr_rdy=1 -> writes (0x10,0xA0)..(0x13,0xA3) on consecutive cycles; done_pulse 2 cycles after the last pop; n_written=4.
- Masking: 4 descriptors with mask=1 on #3 and #4 -> only 0x10 and 0x11 are written; both FIFOs empty at done; n_written=2.
- Backpressure: rtm_wr_rdy low for 3 cycles on the 2nd write -> addr/data held; no pops during the stall; write order preserved; done_pulse delayed 3 cycles.
- Starvation: data_empty toggled every other cycle -> pops only when both FIFOs are non-empty; desc_rd_en==data_rd_en every cycle.
- Boundary: 5 descriptors queued with last on #3; start_pulse pulsed while busy -> exactly 3 pops, descriptors #4 and #5 remain in the FIFO, the second start is ignored; a fresh start after done consumes #4 and #5.
- Reset: rst_n=0 while rtm_wr_en=1 stalled -> all outputs 0 immediately, state IDLE; a subsequent start runs normally.

Source files
------------

// File: rtl/pool_wb_exec.sv
// Write-back executor for the pooling unit: pops descriptor/data pairs in lockstep
// and issues registered RTM writes, with backpressure and per-instruction sequencing.
module pool_wb_exec #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_pulse,
    input  logic              desc_empty,
    input  logic [ADDR_W-1:0] desc_addr,
    input  logic              desc_mask,
    input  logic              desc_last,
    output logic              desc_rd_en,
    input  logic              data_empty,
    input  logic [DATA_W-1:0] data_dout,
    output logic              data_rd_en,
    output logic              rtm_wr_en,
    output logic [ADDR_W-1:0] rtm_wr_addr,
    output logic [DATA_W-1:0] rtm_wr_data,
    input  logic              rtm_wr_rdy,
    output logic              busy,
    output logic              done_pulse,
    output logic [15:0]       n_written
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state;
    logic   reg_free;
    logic   pop;

    // The output register can take a new word when it is empty or its write is accepted now
    assign reg_free   = ~rtm_wr_en | rtm_wr_rdy;
    assign pop        = (state == RUN) & ~desc_empty & ~data_empty & reg_free;
    assign desc_rd_en = pop;
    assign data_rd_en = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rtm_wr_en   <= 1'b0;
            rtm_wr_addr <= '0;
            rtm_wr_data <= '0;
            busy        <= 1'b0;
            done_pulse  <= 1'b0;
            n_written   <= 16'd0;
        end else begin
            done_pulse <= 1'b0;

            if (pop && !desc_mask) begin
                rtm_wr_en   <= 1'b1;
                rtm_wr_addr <= desc_addr;
                rtm_wr_data <= data_dout;
                if (n_written != 16'hFFFF) begin
                    n_written <= n_written + 16'd1;
                end
            end else if (reg_free) begin
                rtm_wr_en <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        n_written <= 16'd0;
                    end
                end
                RUN: begin
                    // Words after the last descriptor belong to the next instruction
                    if (pop && desc_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (reg_free) begin
                        state      <= DONE;
                        done_pulse <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_wb_exec.sv
// Directed bench for pool_wb_exec: queue-modelled FWFT FIFOs, an RTM ready driver
// and a write log compared against hand-computed expectations.
module tb_pool_wb_exec;

    typedef struct {
        logic [11:0] addr;
        logic        mask;
        logic        last;
    } desc_t;

    logic        clk;
    logic        rst_n;
    logic        start_pulse;
    logic        desc_empty;
    logic [11:0] desc_addr;
    logic        desc_mask;
    logic        desc_last;
    logic        desc_rd_en;
    logic        data_empty;
    logic [63:0] data_dout;
    logic        data_rd_en;
    logic        rtm_wr_en;
    logic [11:0] rtm_wr_addr;
    logic [63:0] rtm_wr_data;
    logic        rtm_wr_rdy;
    logic        busy;
    logic        done_pulse;
    logic [15:0] n_written;

    desc_t       dq[$];
    logic [63:0] dataq[$];
    logic [11:0] wr_addr_log[$];
    logic [63:0] wr_data_log[$];

    int  cyc;
    int  pop_cnt;
    int  viol;
    int  last_pop_cyc;
    int  check_count;
    int  pass_count;
    bit  starve_mode;
    bit  starve_phase;
    bit  rdy_low;
    bit  stall_en;
    int  stall_cnt;
    logic [11:0] stall_addr;
    bit  held_valid;
    logic [11:0] held_addr;
    logic [63:0] held_data;

    pool_wb_exec #(.ADDR_W(12), .DATA_W(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_pulse(start_pulse),
        .desc_empty(desc_empty),
        .desc_addr(desc_addr),
        .desc_mask(desc_mask),
        .desc_last(desc_last),
        .desc_rd_en(desc_rd_en),
        .data_empty(data_empty),
        .data_dout(data_dout),
        .data_rd_en(data_rd_en),
        .rtm_wr_en(rtm_wr_en),
        .rtm_wr_addr(rtm_wr_addr),
        .rtm_wr_data(rtm_wr_data),
        .rtm_wr_rdy(rtm_wr_rdy),
        .busy(busy),
        .done_pulse(done_pulse),
        .n_written(n_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol watcher: logs accepted writes, pops the FIFO models, flags illegal behaviour
    always @(posedge clk) begin
        if (desc_rd_en != data_rd_en) viol++;
        if (desc_rd_en && desc_empty) viol++;
        if (data_rd_en && data_empty) viol++;
        if (desc_rd_en && rtm_wr_en && !rtm_wr_rdy) viol++;
        if (held_valid && rtm_wr_en && (rtm_wr_addr != held_addr || rtm_wr_data != held_data)) viol++;
        if (rtm_wr_en && rtm_wr_rdy) begin
            wr_addr_log.push_back(rtm_wr_addr);
            wr_data_log.push_back(rtm_wr_data);
        end
        held_valid = rtm_wr_en && !rtm_wr_rdy;
        held_addr  = rtm_wr_addr;
        held_data  = rtm_wr_data;
        if (desc_rd_en && dq.size() > 0) begin
            pop_cnt++;
            if (dq[0].last) last_pop_cyc = cyc;
            void'(dq.pop_front());
        end
        if (data_rd_en && dataq.size() > 0) void'(dataq.pop_front());
        cyc++;
    end

    // FWFT heads, optional data starvation and RTM ready pattern
    always @(negedge clk) begin
        desc_empty = (dq.size() == 0);
        desc_addr  = desc_empty ? 12'h0 : dq[0].addr;
        desc_mask  = desc_empty ? 1'b0  : dq[0].mask;
        desc_last  = desc_empty ? 1'b0  : dq[0].last;
        starve_phase = ~starve_phase;
        data_empty = (dataq.size() == 0) || (starve_mode && starve_phase);
        data_dout  = (dataq.size() == 0) ? 64'h0 : dataq[0];
        if (rdy_low) begin
            rtm_wr_rdy = 1'b0;
        end else if (stall_en && rtm_wr_en && rtm_wr_addr == stall_addr && stall_cnt < 3) begin
            rtm_wr_rdy = 1'b0;
            stall_cnt++;
        end else begin
            rtm_wr_rdy = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic loadFifos(input int n, input logic [11:0] base_addr, input logic [63:0] base_data,
                             input logic [7:0] mask_bits, input logic [7:0] last_bits);
        desc_t d;
        for (int i = 0; i < n; i++) begin
            d.addr = base_addr + 12'(i);
            d.mask = mask_bits[i];
            d.last = last_bits[i];
            dq.push_back(d);
            dataq.push_back(base_data + 64'(i));
        end
        repeat (2) @(negedge clk);
    endtask

    // Pulses start and waits (bounded) for done_pulse; cycles are relative to the start cycle
    task automatic applyStimulus(input string tag, output int start_cyc, output int done_cyc);
        bit found;
        wr_addr_log.delete();
        wr_data_log.delete();
        pop_cnt = 0;
        viol    = 0;
        found   = 0;
        done_cyc = -1;
        @(negedge clk);
        start_pulse = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        start_pulse = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (done_pulse) begin
                found    = 1;
                done_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!found) checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic checkWrites(input string tag, input int n, input logic [11:0] base_addr,
                               input logic [63:0] base_data);
        checkOutput({tag, "_wr_count"}, 64'(wr_addr_log.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
            checkOutput($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_addr_log[i]), 64'(base_addr + 12'(i)));
            checkOutput($sformatf("%s_wr%0d_data", tag, i), wr_data_log[i], base_data + 64'(i));
        end
    endtask

    initial begin
        int s, d;
        check_count = 0;
        pass_count  = 0;
        cyc = 0;
        viol = 0;
        pop_cnt = 0;
        last_pop_cyc = 0;
        starve_mode = 0;
        starve_phase = 0;
        rdy_low = 0;
        stall_en = 0;
        stall_cnt = 0;
        stall_addr = 12'h0;
        held_valid = 0;
        held_addr = 12'h0;
        held_data = 64'h0;
        rst_n = 1'b0;
        start_pulse = 1'b0;
        desc_empty = 1'b1;
        desc_addr = 12'h0;
        desc_mask = 1'b0;
        desc_last = 1'b0;
        data_empty = 1'b1;
        data_dout = 64'h0;
        rtm_wr_rdy = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_wr_en", 64'(rtm_wr_en), 64'd0);
        checkOutput("reset_n_written", 64'(n_written), 64'd0);
        checkOutput("reset_rd_en", 64'(desc_rd_en | data_rd_en), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run
        loadFifos(4, 12'h010, 64'hA0, 8'b0000, 8'b1000);
        applyStimulus("basic", s, d);
        checkWrites("basic", 4, 12'h010, 64'hA0);
        checkOutput("basic_n_written", 64'(n_written), 64'd4);
        checkOutput("basic_done_after_pop", 64'(d - last_pop_cyc), 64'd2);
        checkOutput("basic_latency", 64'(d - s), 64'd6);
        checkOutput("basic_protocol", 64'(viol), 64'd0);
        @(negedge clk);
        checkOutput("basic_done_one_cycle", 64'(done_pulse), 64'd0);
        checkOutput("basic_idle", 64'(busy), 64'd0);

        // Masking
        loadFifos(4, 12'h010, 64'hA0, 8'b1100, 8'b1000);
        applyStimulus("mask", s, d);
        checkWrites("mask", 2, 12'h010, 64'hA0);
        checkOutput("mask_n_written", 64'(n_written), 64'd2);
        checkOutput("mask_desc_left", 64'(dq.size()), 64'd0);
        checkOutput("mask_data_left", 64'(dataq.size()), 64'd0);
        checkOutput("mask_protocol", 64'(viol), 64'd0);

        // Backpressure on the second write
        stall_en = 1;
        stall_cnt = 0;
        stall_addr = 12'h011;
        loadFifos(4, 12'h010, 64'hA0, 8'b0000, 8'b1000);
        applyStimulus("stall", s, d);
        stall_en = 0;
        checkWrites("stall", 4, 12'h010, 64'hA0);
        checkOutput("stall_latency", 64'(d - s), 64'd9);
        checkOutput("stall_cycles", 64'(stall_cnt), 64'd3);
        checkOutput("stall_protocol", 64'(viol), 64'd0);

        // Data starvation
        starve_mode = 1;
        loadFifos(4, 12'h020, 64'hB0, 8'b0000, 8'b1000);
        applyStimulus("starve", s, d);
        starve_mode = 0;
        checkWrites("starve", 4, 12'h020, 64'hB0);
        checkOutput("starve_n_written", 64'(n_written), 64'd4);
        checkOutput("starve_protocol", 64'(viol), 64'd0);

        // Last descriptor boundary plus an ignored start while busy
        loadFifos(5, 12'h030, 64'hC0, 8'b00000, 8'b10100);
        wr_addr_log.delete();
        wr_data_log.delete();
        pop_cnt = 0;
        viol = 0;
        @(negedge clk);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        @(negedge clk);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        for (int i = 0; i < 60 && !done_pulse; i++) @(negedge clk);
        checkOutput("bound_done_seen", 64'(done_pulse), 64'd1);
        repeat (4) @(negedge clk);
        checkOutput("bound_pops", 64'(pop_cnt), 64'd3);
        checkOutput("bound_desc_left", 64'(dq.size()), 64'd2);
        checkOutput("bound_data_left", 64'(dataq.size()), 64'd2);
        checkOutput("bound_n_written", 64'(n_written), 64'd3);
        checkOutput("bound_idle", 64'(busy), 64'd0);
        checkWrites("bound", 3, 12'h030, 64'hC0);
        applyStimulus("bound2", s, d);
        checkWrites("bound2", 2, 12'h033, 64'hC3);
        checkOutput("bound2_n_written", 64'(n_written), 64'd2);
        checkOutput("bound2_desc_left", 64'(dq.size()), 64'd0);

        // Async reset while a write is stalled
        rdy_low = 1;
        loadFifos(4, 12'h050, 64'hD0, 8'b0000, 8'b1000);
        @(negedge clk);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        for (int i = 0; i < 20 && !rtm_wr_en; i++) @(negedge clk);
        checkOutput("rst_pre_wr_en", 64'(rtm_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wr_en", 64'(rtm_wr_en), 64'd0);
        checkOutput("rst_wr_addr", 64'(rtm_wr_addr), 64'd0);
        checkOutput("rst_wr_data", rtm_wr_data, 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_n_written", 64'(n_written), 64'd0);
        checkOutput("rst_rd_en", 64'(desc_rd_en | data_rd_en), 64'd0);
        @(negedge clk);
        rdy_low = 0;
        dq.delete();
        dataq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        loadFifos(4, 12'h060, 64'hE0, 8'b0000, 8'b1000);
        applyStimulus("post_rst", s, d);
        checkWrites("post_rst", 4, 12'h060, 64'hE0);
        checkOutput("post_rst_n_written", 64'(n_written), 64'd4);
        checkOutput("post_rst_latency", 64'(d - s), 64'd6);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
